// File: rtl/parallel_interface.sv
// Parallel-to-serial converter: captures a WIDTH-bit word on req, pulses grant
// for one cycle, then shifts the word out MSB-first with out_data marking valid bits.
module parallel_interface #(
    parameter int WIDTH = 32
) (
    input  logic             p_clk,
    input  logic             n_rst,
    input  logic             req,
    input  logic [WIDTH-1:0] parallel_data_in,
    output logic             grant,
    output logic             serial_data_out,
    output logic             out_data
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_grant;
    logic               w_grant_nxt;
    logic               r_sdo;
    logic               w_sdo_nxt;
    logic               r_vld;
    logic               w_vld_nxt;

    always_ff @(posedge p_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_grant <= 1'b0;
            r_sdo   <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= w_grant_nxt;
            r_sdo   <= w_sdo_nxt;
            r_vld   <= w_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = 1'b0;
        w_sdo_nxt   = 1'b0;
        w_vld_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    // The MSB leaves immediately, so the register keeps only the remaining bits.
                    w_shift_nxt = {parallel_data_in[WIDTH-2:0], 1'b0};
                    w_sdo_nxt   = parallel_data_in[WIDTH-1];
                    w_grant_nxt = 1'b1;
                    w_vld_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST_CNT) begin
                    // All bits sent: this edge only drops out_data; capture waits one cycle.
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_sdo_nxt   = r_shift[WIDTH-1];
                    w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                    w_vld_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign grant           = r_grant;
    assign serial_data_out = r_sdo;
    assign out_data        = r_vld;

endmodule

// File: tb/tb_parallel_interface.sv
// Directed bench for parallel_interface: a cycle-level protocol model pushes the
// expected serial bits into a queue at each capture and pops them as out_data runs.
module tb_parallel_interface;

    localparam int W = 32;

    logic         p_clk;
    logic         n_rst;
    logic         req;
    logic [W-1:0] parallel_data_in;
    logic         grant;
    logic         serial_data_out;
    logic         out_data;

    int checks   = 0;
    int failures = 0;

    bit exp_q[$];
    int m_rem     = 0;
    bit exp_grant = 1'b0;
    int grant_cnt = 0;

    parallel_interface #(.WIDTH(W)) dut (
        .p_clk            (p_clk),
        .n_rst            (n_rst),
        .req              (req),
        .parallel_data_in (parallel_data_in),
        .grant            (grant),
        .serial_data_out  (serial_data_out),
        .out_data         (out_data)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model with the inputs present at the edge,
    // then compare the DUT outputs on the following falling edge.
    task automatic run(input int n);
        bit exp_vld;
        bit exp_bit;
        for (int c = 0; c < n; c++) begin
            exp_grant = 1'b0;
            if (!n_rst) begin
                m_rem = 0;
                exp_q.delete();
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem > 0) void'(exp_q.pop_front());
                else exp_q.delete();
            end else if (req) begin
                exp_q.delete();
                for (int b = W - 1; b >= 0; b--) exp_q.push_back(parallel_data_in[b]);
                m_rem     = W;
                exp_grant = 1'b1;
            end
            @(posedge p_clk);
            @(negedge p_clk);
            exp_vld = (m_rem > 0);
            exp_bit = (exp_vld && exp_q.size() > 0) ? exp_q[0] : 1'b0;
            if (grant === 1'b1) grant_cnt++;
            chk("grant", {31'd0, grant}, {31'd0, exp_grant});
            chk("out_data", {31'd0, out_data}, {31'd0, exp_vld});
            chk("serial_data_out", {31'd0, serial_data_out}, {31'd0, exp_bit});
        end
    endtask

    initial begin
        n_rst            = 1'b0;
        req              = 1'b1;
        parallel_data_in = 32'hA5A5_A5A5;

        // reset held with a pending request: nothing may come out
        run(3);
        n_rst = 1'b1;
        run(1);
        chk("grant_after_release", {31'd0, grant}, 32'd1);
        req = 1'b0;
        run(W + 2);

        // single word
        grant_cnt        = 0;
        req              = 1'b1;
        parallel_data_in = 32'h1111_1111;
        run(1);
        req = 1'b0;
        run(W + 2);
        chk("single_grant_count", grant_cnt, 32'd1);

        // data changes during shift with req held; second word follows after one idle cycle
        req              = 1'b1;
        parallel_data_in = 32'h1111_1111;
        run(1);
        parallel_data_in = 32'hFFFF_FFFF;
        run(W + 1);
        chk("second_capture_grant", {31'd0, grant}, 32'd1);
        req = 1'b0;
        run(W + 2);

        // asynchronous reset in the middle of a word
        req              = 1'b1;
        parallel_data_in = 32'hDEAD_BEEF;
        run(1);
        req = 1'b0;
        run(10);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_out_data", {31'd0, out_data}, 32'd0);
        chk("async_rst_sdo", {31'd0, serial_data_out}, 32'd0);
        chk("async_rst_grant", {31'd0, grant}, 32'd0);
        @(negedge p_clk);
        run(2);
        n_rst = 1'b1;
        run(5);

        // continuous request with constant data repeats the frame
        grant_cnt        = 0;
        req              = 1'b1;
        parallel_data_in = 32'h8000_0001;
        run(3 * (W + 1));
        req = 1'b0;
        run(W + 2);
        chk("repeat_grant_count", grant_cnt, 32'd3);

        // long idle stretch
        grant_cnt = 0;
        run(100);
        chk("idle_grant_count", grant_cnt, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
